ram128_arbiter: RTL and testbench
=================================

Name: ram128_arbiter

Overview:
- Two-requester controller in front of one RAM128 instance (128 words x WSIZE bytes, single port, synchronous, byte write enables).
- Sequences a zero-fill of the whole array after reset or on request.
- Afterwards, arbitrates one access per cycle between requester A (CPU/Wishbone side) and requester B (DMA/AXIS side).
- Returns read data with fixed 1-cycle latency.

Parameters:
- WSIZE, 4, bytes per word; data width is WSIZE*8.
- AW, 7, address width (depth 2**AW = 128).
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins.
- INIT_ON_RST, 1, 1 = zero-fill automatically after reset; 0 = start in RUN.

Ports:
- CLK, in, 1, single clock; also drives RAM128 CLK.
- RST, in, 1, synchronous, active-high reset.
- init_req, in, 1, single-cycle pulse; starts a zero-fill.
- init_done, out, 1, high while in RUN.
- a_req, in, 1, requester A access request.
- a_we, in, WSIZE, A byte write enables; all zero = read.
- a_addr, in, AW, A word address.
- a_wdata, in, WSIZE*8, A write data.
- a_gnt, out, 1, A request accepted this cycle.
- a_rvalid, out, 1, A read data valid.
- a_rdata, out, WSIZE*8, A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- WE0, out, WSIZE, RAM byte write enables.
- EN0, out, 1, RAM enable.
- A0, out, AW, RAM address.
- Di0, out, WSIZE*8, RAM write data.
- Do0, in, WSIZE*8, RAM read data; valid the cycle after an enabled read.

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset values:
  - FSM = INIT if INIT_ON_RST, else RUN.
  - init counter = 0; init_done = 0 (1 if INIT_ON_RST = 0).
  - a_rvalid = b_rvalid = 0; last-grant register = B, so A wins the first tie.
  - a_gnt, b_gnt, EN0 and WE0 are 0 during the reset cycle.
  - a_rdata and b_rdata are continuously Do0.
- INIT state:
  - EN0 = 1, WE0 = all ones, Di0 = 0, A0 = counter, one word per cycle.
  - Counter increments each cycle; after writing address 127, FSM moves to RUN.
  - Exactly 128 cycles; init_done rises on the following cycle.
  - Grants and rvalids are 0 throughout; requesters simply hold req.
- RUN state, per cycle:
  - Grant is combinational from the current a_req and b_req.
  - Only A requesting: A wins. Only B requesting: B wins.
  - Both requesting: FIXED_PRIO = 1 gives A; otherwise the requester not granted last time wins.
  - The last-grant register updates only on a grant.
  - Winner's gnt = 1 and its we/addr/wdata drive WE0/A0/Di0 combinationally, with EN0 = 1.
  - No request: EN0 = 0, WE0 = 0.
  - Loser holds req, addr and data stable until granted.
  - req/gnt follow valid/ready: the transfer occurs on the cycle both are high.
- Read response:
  - A granted read (we == 0) sets the winner's rvalid = 1 in the next cycle only.
  - rdata is Do0 and is valid only while rvalid is high.
  - Granted writes produce no rvalid.
  - Back-to-back reads give rvalid every cycle (full throughput).
- init_req in RUN:
  - The current cycle's grant still completes; INIT starts next cycle with counter = 0.
  - A pending rvalid from the last cycle is still delivered.
- init_req in INIT: ignored; the counter is not restarted.
- RST mid-INIT or mid-RUN: rvalids drop immediately, FSM and counter reload their reset values, and any in-flight read is discarded.
- Address and width handling:
  - Addresses are taken as-is; there is no wrap logic beyond AW bits.
  - The init counter is AW+1 bits wide; terminal count is 2**AW - 1.

Decomposition:
- Package ram128_ctrl_pkg holds:
  - the state enum {ST_INIT, ST_RUN};
  - the grant encoding {GNT_A, GNT_B};
  - constants DEPTH = 2**AW and the init terminal count.
- One natural sub-module, rr_arb2:
  - 2-way arbiter with a last-grant register and FIXED_PRIO;
  - inputs: req[1:0], advance; outputs: gnt[1:0].
- Top-level holds the FSM, the init counter, the RAM mux and the rvalid pipeline flops.

Test Plan:
- Reset with INIT_ON_RST = 1 → EN0 = 1 and WE0 = 4'hF for exactly 128 cycles, A0 stepping 0..127 with Di0 = 0; init_done = 1 on cycle 129; no gnt during the fill.
- After init, A writes 0xDEADBEEF to addr 5 with we = 4'hF, then reads addr 5 → a_gnt is 1 on each request cycle; a_rvalid = 1 one cycle after the read; a_rdata = 0xDEADBEEF; b_rvalid stays 0.
- Byte write: B writes 0x000000AA to addr 5 with we = 4'b0001, then B reads addr 5 → b_rdata = 0xDEADBEAA.
- a_req and b_req held high for 6 cycles, all reads, FIXED_PRIO = 0 → grants A, B, A, B, A, B; rvalids alternate one cycle later. With FIXED_PRIO = 1 → A all 6 cycles and b_gnt = 0.
- init_req pulsed on the same cycle as a granted A read of addr 3 → a_rvalid = 1 next cycle with the old data; INIT then runs 128 cycles; a subsequent read of addr 3 returns 0.
- RST asserted on fill cycle 40 → counter restarts at 0 and a full 128-cycle fill follows. RST asserted the cycle after a granted read → that rvalid is 0 and the read is discarded.

Source files
------------

// File: rtl/ram128_arbiter_pkg.sv
// Shared types and constants for the RAM128 two-requester controller.
// Holds the controller FSM states, the grant encoding and the zero-fill bounds.
package ram128_ctrl_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  typedef enum logic {GNT_A, GNT_B} grant_e;

  localparam int AW_DEF    = 7;
  localparam int DEPTH     = 2 ** AW_DEF;
  localparam int INIT_LAST = DEPTH - 1;

  // Last address written by the zero-fill for an arbitrary address width.
  function automatic int init_last(input int aw);
    return (2 ** aw) - 1;
  endfunction

endpackage

// File: rtl/ram128_arbiter_rr_arb2.sv
// Two-way arbiter: combinational grant from the current requests.
// A remembered last winner decides ties unless A is given fixed priority.
module rr_arb2
  import ram128_ctrl_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  grant_e last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ((FIXED_PRIO != 0) || (last == GNT_B)) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Starts as B so that A wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= GNT_B;
    end else if (advance && gnt[0]) begin
      last <= GNT_A;
    end else if (advance && gnt[1]) begin
      last <= GNT_B;
    end
  end

endmodule

// File: rtl/ram128_arbiter.sv
// RAM128 front end: zero-fills the array, then arbitrates one access per cycle
// between requesters A and B, returning read data with a fixed 1-cycle latency.
module ram128_arbiter
  import ram128_ctrl_pkg::*;
#(
  parameter int WSIZE       = 4,
  parameter int AW          = 7,
  parameter int FIXED_PRIO  = 0,
  parameter int INIT_ON_RST = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               init_req,
  output logic               init_done,
  input  logic               a_req,
  input  logic [WSIZE-1:0]   a_we,
  input  logic [AW-1:0]      a_addr,
  input  logic [WSIZE*8-1:0] a_wdata,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [WSIZE*8-1:0] a_rdata,
  input  logic               b_req,
  input  logic [WSIZE-1:0]   b_we,
  input  logic [AW-1:0]      b_addr,
  input  logic [WSIZE*8-1:0] b_wdata,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic [WSIZE*8-1:0] b_rdata,
  output logic [WSIZE-1:0]   WE0,
  output logic               EN0,
  output logic [AW-1:0]      A0,
  output logic [WSIZE*8-1:0] Di0,
  input  logic [WSIZE*8-1:0] Do0
);

  localparam int     LAST_CNT  = init_last(AW);
  localparam state_e RST_STATE = (INIT_ON_RST != 0) ? ST_INIT : ST_RUN;

  state_e      state;
  state_e      state_nxt;
  logic [AW:0] cnt;
  logic        run;
  logic        fill_end;
  logic [1:0]  gnt;
  logic        a_rv_q;
  logic        b_rv_q;

  assign run      = (state == ST_RUN) && !RST;
  assign fill_end = (cnt == LAST_CNT[AW:0]);

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk    (CLK),
    .rst    (RST),
    .req    ({b_req, a_req} & {2{run}}),
    .advance(run),
    .gnt    (gnt)
  );

  assign a_gnt     = gnt[0];
  assign b_gnt     = gnt[1];
  assign init_done = (state == ST_RUN);
  assign a_rdata   = Do0;
  assign b_rdata   = Do0;
  // Reset kills a response already in flight in the same cycle.
  assign a_rvalid  = a_rv_q && !RST;
  assign b_rvalid  = b_rv_q && !RST;

  always_comb begin
    state_nxt = state;
    EN0       = 1'b0;
    WE0       = '0;
    A0        = '0;
    Di0       = '0;
    case (state)
      ST_INIT: begin
        EN0 = !RST;
        WE0 = {WSIZE{!RST}};
        A0  = cnt[AW-1:0];
        if (fill_end) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (init_req) state_nxt = ST_INIT;
        if (gnt[0]) begin
          EN0 = 1'b1;
          WE0 = a_we;
          A0  = a_addr;
          Di0 = a_wdata;
        end else if (gnt[1]) begin
          EN0 = 1'b1;
          WE0 = b_we;
          A0  = b_addr;
          Di0 = b_wdata;
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (state == ST_INIT) begin
      cnt <= fill_end ? '0 : cnt + 1'b1;
    end else if (init_req) begin
      cnt <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
    end else begin
      a_rv_q <= gnt[0] && (a_we == '0);
      b_rv_q <= gnt[1] && (b_we == '0);
    end
  end

endmodule

// File: tb/tb_ram128_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus;
// the round-robin one talks to a behavioural RAM and is scored against a word-level model.
module tb_ram128_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        init_req;
  logic        a_req, b_req;
  logic [3:0]  a_we, b_we;
  logic [6:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic        d0_init_done, d0_a_gnt, d0_a_rvalid, d0_b_gnt, d0_b_rvalid, d0_EN0;
  logic [31:0] d0_a_rdata, d0_b_rdata, d0_Di0, d0_Do0;
  logic [3:0]  d0_WE0;
  logic [6:0]  d0_A0;
  logic        d1_init_done, d1_a_gnt, d1_a_rvalid, d1_b_gnt, d1_b_rvalid, d1_EN0;
  logic [31:0] d1_a_rdata, d1_b_rdata, d1_Di0;
  logic [31:0] d1_Do0 = 32'h0;
  logic [3:0]  d1_WE0;
  logic [6:0]  d1_A0;

  logic [31:0] ram0    [0:127];
  logic [31:0] ref_mem [0:127];
  bit          last_a;
  bit          pend_a, pend_b;
  logic [31:0] pend_data;
  int          last_win;
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  ram128_arbiter #(.WSIZE(4), .AW(7), .FIXED_PRIO(0), .INIT_ON_RST(1)) dut0 (
    .CLK(CLK), .RST(RST), .init_req(init_req), .init_done(d0_init_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(d0_a_gnt), .a_rvalid(d0_a_rvalid), .a_rdata(d0_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(d0_b_gnt), .b_rvalid(d0_b_rvalid), .b_rdata(d0_b_rdata),
    .WE0(d0_WE0), .EN0(d0_EN0), .A0(d0_A0), .Di0(d0_Di0), .Do0(d0_Do0)
  );

  ram128_arbiter #(.WSIZE(4), .AW(7), .FIXED_PRIO(1), .INIT_ON_RST(1)) dut1 (
    .CLK(CLK), .RST(RST), .init_req(init_req), .init_done(d1_init_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(d1_a_gnt), .a_rvalid(d1_a_rvalid), .a_rdata(d1_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(d1_b_gnt), .b_rvalid(d1_b_rvalid), .b_rdata(d1_b_rdata),
    .WE0(d1_WE0), .EN0(d1_EN0), .A0(d1_A0), .Di0(d1_Di0), .Do0(d1_Do0)
  );

  // Behavioural RAM128: synchronous, byte write enables, read data the next cycle.
  always @(posedge CLK) begin
    if (d0_EN0) begin
      if (d0_WE0 == 4'h0) begin
        d0_Do0 <= ram0[d0_A0];
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (d0_WE0[k]) ram0[d0_A0][8*k +: 8] <= d0_Di0[8*k +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input bit ar, input logic [3:0] awe, input logic [6:0] aad,
                               input logic [31:0] awd, input bit br, input logic [3:0] bwe,
                               input logic [6:0] bad, input logic [31:0] bwd, input bit ireq);
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = bad; b_wdata = bwd;
    init_req = ireq;
  endtask

  task automatic checkRvalid();
    checkOutput("a_rvalid", 64'(d0_a_rvalid), 64'(pend_a));
    checkOutput("b_rvalid", 64'(d0_b_rvalid), 64'(pend_b));
    if (pend_a) checkOutput("a_rdata", 64'(d0_a_rdata), 64'(pend_data));
    if (pend_b) checkOutput("b_rdata", 64'(d0_b_rdata), 64'(pend_data));
  endtask

  // One RUN cycle: predict winner and port values from the arbitration rules.
  task automatic runCycle();
    int          win;
    logic [3:0]  we;
    logic [6:0]  ad;
    logic [31:0] wd;
    #4;
    win = 0;
    if (a_req && b_req) win = last_a ? 2 : 1;
    else if (a_req)     win = 1;
    else if (b_req)     win = 2;
    we = (win == 1) ? a_we    : (win == 2) ? b_we    : 4'h0;
    ad = (win == 1) ? a_addr  : (win == 2) ? b_addr  : 7'h0;
    wd = (win == 1) ? a_wdata : (win == 2) ? b_wdata : 32'h0;
    checkOutput("init_done", 64'(d0_init_done), 64'(1'b1));
    checkOutput("gnt", 64'({d0_a_gnt, d0_b_gnt}), 64'({win == 1, win == 2}));
    checkOutput("gnt_fixed", 64'({d1_a_gnt, d1_b_gnt}), 64'({a_req, b_req && !a_req}));
    checkOutput("en0", 64'(d0_EN0), 64'(win != 0));
    checkOutput("we0", 64'(d0_WE0), 64'(we));
    if (win != 0) checkOutput("ram_port", 64'({d0_A0, d0_Di0}), 64'({ad, wd}));
    checkRvalid();
    pend_a = (win == 1) && (we == 4'h0);
    pend_b = (win == 2) && (we == 4'h0);
    if (win != 0 && we == 4'h0) pend_data = ref_mem[ad];
    if (win != 0) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) ref_mem[ad][8*k +: 8] = wd[8*k +: 8];
      end
    end
    if (win == 1)      last_a = 1'b1;
    else if (win == 2) last_a = 1'b0;
    last_win = win;
    tick();
  endtask

  // Zero-fill cycles; an init_req pulse at cycle pulse_at must not restart the count.
  task automatic doFill(input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      init_req = (i == pulse_at);
      #4;
      checkOutput("fill_port", 64'({d0_EN0, d0_WE0, d0_A0, d0_Di0}),
                  64'({1'b1, 4'hF, 7'(i), 32'h0}));
      checkOutput("fill_gnt", 64'({d0_a_gnt, d0_b_gnt, d1_a_gnt, d1_b_gnt, d0_init_done}), '0);
      checkRvalid();
      pend_a = 1'b0;
      pend_b = 1'b0;
      ref_mem[i] = 32'h0;
      tick();
    end
    init_req = 1'b0;
  endtask

  task automatic resetCycle();
    RST = 1'b1;
    #4;
    checkOutput("rst_ram", 64'({d0_EN0, d0_WE0}), '0);
    checkOutput("rst_gnt", 64'({d0_a_gnt, d0_b_gnt, d1_a_gnt, d1_b_gnt}), '0);
    checkOutput("rst_rvalid", 64'({d0_a_rvalid, d0_b_rvalid}), '0);
    tick();
    RST = 1'b0;
    pend_a = 1'b0;
    pend_b = 1'b0;
    last_a = 1'b0;
  endtask

  initial begin
    last_win = 0;
    pend_data = 32'h0;
    RST = 1'b1;
    applyStimulus(1, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    resetCycle();
    resetCycle();
    doFill(128, -1);

    // First RUN cycle: A has held its read through the whole fill.
    runCycle();
    applyStimulus(1, 4'hF, 7'd5, 32'hDEADBEEF, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();
    applyStimulus(1, 4'h0, 7'd5, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();
    checkOutput("a_rdata_deadbeef", 64'(d0_a_rdata), 64'(32'hDEADBEEF));
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();

    applyStimulus(0, 4'h0, 7'd0, 32'h0, 1, 4'b0001, 7'd5, 32'h000000AA, 0);
    runCycle();
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 1, 4'h0, 7'd5, 32'h0, 0);
    runCycle();
    checkOutput("b_rdata_byte", 64'(d0_b_rdata), 64'(32'hDEADBEAA));
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();

    applyStimulus(1, 4'h0, 7'd5, 32'h0, 1, 4'h0, 7'd0, 32'h0, 0);
    for (int i = 0; i < 6; i++) runCycle();
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();

    // Random traffic; a requester only changes its request once granted or idle.
    for (int c = 0; c < 300; c++) begin
      if (!a_req || last_win == 1) begin
        a_req   = 1'($urandom_range(0, 1));
        a_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        a_addr  = 7'($urandom_range(0, 7));
        a_wdata = $urandom;
      end
      if (!b_req || last_win == 2) begin
        b_req   = 1'($urandom_range(0, 1));
        b_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        b_addr  = 7'($urandom_range(0, 7));
        b_wdata = $urandom;
      end
      runCycle();
    end
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();

    // init_req alongside a granted read: old data still returned, then fill.
    applyStimulus(1, 4'hF, 7'd3, 32'h12345678, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();
    applyStimulus(1, 4'h0, 7'd3, 32'h0, 0, 4'h0, 7'd0, 32'h0, 1);
    runCycle();
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    checkOutput("init_req_old_data", 64'({d0_a_rvalid, d0_a_rdata}), 64'({1'b1, 32'h12345678}));
    doFill(128, -1);
    applyStimulus(1, 4'h0, 7'd3, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();
    checkOutput("after_fill_zero", 64'(d0_a_rdata), '0);
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();

    // Reset on fill cycle 40 restarts a complete fill; init_req inside INIT is ignored.
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 1);
    runCycle();
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    doFill(40, -1);
    resetCycle();
    doFill(128, 10);
    applyStimulus(1, 4'h0, 7'd3, 32'h0, 1, 4'h0, 7'd4, 32'h0, 0);
    runCycle();
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 1, 4'h0, 7'd4, 32'h0, 0);
    runCycle();

    // Reset the cycle after a granted read discards its response.
    applyStimulus(1, 4'h0, 7'd3, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    runCycle();
    applyStimulus(0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0, 0);
    resetCycle();
    doFill(128, -1);
    runCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
